// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. It sends one command byte to the keyboard
//   over the open-drain clock/data pair, using the device-clocked handshake:
//   inhibit the clock, request to send, shift out 8 data bits LSB first, then
//   odd parity and stop, and finally check the device ACK.
//
// Ports
//   clock       host clock, all logic on its rising edge
//   reset       asynchronous, active-high
//   tx_data     byte to send, captured when tx_start is accepted
//   tx_start    one-cycle request, accepted only while tx_busy = 0
//   tx_busy     high from accept until tx_done / tx_error
//   tx_done     one-cycle pulse: byte sent and ACK received
//   tx_error    one-cycle pulse: timeout or missing ACK
//   ps2_clk_i   PS/2 clock line level (asynchronous)
//   ps2_dat_i   PS/2 data line level (asynchronous)
//   ps2_clk_oe  1 = pull PS/2 clock low, 0 = release
//   ps2_dat_oe  1 = pull PS/2 data low, 0 = release
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  // One spare bit so the counter can never wrap before the timeout compare fires.
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Line synchronisers: [0] is the metastability stage, [1] the usable level.
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;

  logic clk_fall;
  logic parity;
  logic in_handshake;

  assign clk_fall     = clk_prev_q & ~clk_sync_q[1];
  assign parity       = ~^data_q;
  assign in_handshake = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk_i};
    dat_sync_d = {dat_sync_q[0], ps2_dat_i};
    clk_prev_d = clk_sync_q[1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_start && !busy_q) begin
          data_d   = tx_data;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        // Clock held low; at the end of the window pull data low as the start
        // bit while the clock is still inhibited (request-to-send).
        if (cnt_q == INHIBIT_LAST) begin
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        clk_oe_d  = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = ST_SEND;
      end

      ST_SEND: begin
        // The device samples on its rising edge, so the next bit is placed on
        // the line right after each falling edge.
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!bit_cnt_q[3]) begin
            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            dat_oe_d = ~parity;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          if (!dat_sync_q[1]) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            error_d  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync_q[1] && dat_sync_q[1]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Watchdog on the device clock: every falling edge restarts the count.
    // A completion in the same cycle takes precedence so done and error
    // never pulse together.
    if (in_handshake) begin
      if (clk_fall) begin
        cnt_d = '0;
      end else if (cnt_q == TIMEOUT_LAST && !done_d) begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        error_d  = 1'b1;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // Idle PS/2 lines float high; starting the synchronisers at 1 avoids a
      // phantom falling edge out of reset.
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
    end
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on an
//   open-drain wired-AND bus. The keyboard clocks with a 40-cycle period,
//   samples bits on its rising edge and optionally returns the ACK.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;

  // Device side drivers: 1 = release, 0 = pull low.
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  wire  clk_line = ~ps2_clk_oe & dev_clk;
  wire  dat_line = ~ps2_dat_oe & dev_dat;

  int n_checks = 0;
  int n_fail   = 0;

  // Device results
  logic [7:0] rx_byte;
  logic       rx_start, rx_par, rx_stop, rx_rts;
  // Monitor results
  int mon_done, mon_err, mon_bad, mon_inh, mon_rel_cyc, mon_err_cyc;
  logic inj_busy;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_i(clk_line), .ps2_dat_i(dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, then clocks 10 bits in and
  // optionally pulls data low for the ACK on the 11th clock.
  task automatic device_run(input bit do_clock, input bit do_ack);
    logic [9:0] sh;
    sh = '0;
    rx_rts = 1'b0;
    rx_start = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (clk_line && !dat_line) begin
        rx_rts = 1'b1;
        break;
      end
    end
    if (rx_rts && do_clock) begin
      rx_start = dat_line;
      repeat (5) @(negedge clk);
      for (int b = 0; b < 10; b++) begin
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        sh[b] = dat_line;
        repeat (HALF) @(negedge clk);
      end
      if (do_ack) dev_dat = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
      dev_dat = 1'b1;
    end
    rx_byte = sh[7:0];
    rx_par  = sh[8];
    rx_stop = sh[9];
  endtask

  // Watches the host status until a result appears, then 50 more cycles to
  // catch duplicate pulses.
  task automatic monitor(input int budget);
    int post;
    logic prev_oe;
    mon_done = 0; mon_err = 0; mon_bad = 0; mon_inh = 0;
    mon_rel_cyc = -1; mon_err_cyc = -1;
    post = 0;
    prev_oe = ps2_clk_oe;
    for (int cyc = 0; cyc < budget && post < 50; cyc++) begin
      @(negedge clk);
      if (ps2_clk_oe) mon_inh++;
      if (prev_oe && !ps2_clk_oe && mon_rel_cyc < 0) mon_rel_cyc = cyc;
      prev_oe = ps2_clk_oe;
      if (tx_done) begin
        mon_done++;
        if (tx_busy) mon_bad++;
      end
      if (tx_error) begin
        mon_err++;
        if (mon_err_cyc < 0) mon_err_cyc = cyc;
        if (tx_busy) mon_bad++;
      end
      if (tx_done && tx_error) mon_bad++;
      if (mon_done + mon_err > 0) post++;
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit do_clock, input bit do_ack, input bit inject);
    fork
      do_start(b);
      device_run(do_clock, do_ack);
      monitor(3000);
      begin
        if (inject) begin
          repeat (200) @(negedge clk);
          inj_busy = tx_busy;
          tx_data  = 8'h55;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
        end
      end
    join
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    n_checks++; if (tx_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", tx_error); end
    n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL reset_oe: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_send_ed;
    run_xfer(8'hED, 1'b1, 1'b1, 1'b0);
    n_checks++; if (rx_rts !== 1'b1) begin n_fail++; $display("FAIL ed_rts: got %b expected 1", rx_rts); end
    n_checks++; if (mon_inh < INH || mon_inh > INH + 2) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d expected %0d..%0d", mon_inh, INH, INH + 2); end
    n_checks++; if (rx_start !== 1'b0) begin n_fail++; $display("FAIL ed_start_bit: got %b expected 0", rx_start); end
    n_checks++; if (rx_byte !== 8'hED) begin n_fail++; $display("FAIL ed_byte: got %h expected ed", rx_byte); end
    n_checks++; if (rx_par !== 1'b1) begin n_fail++; $display("FAIL ed_parity: got %b expected 1", rx_par); end
    n_checks++; if (rx_stop !== 1'b1) begin n_fail++; $display("FAIL ed_stop: got %b expected 1", rx_stop); end
    n_checks++; if (mon_done !== 1 || mon_err !== 0) begin n_fail++; $display("FAIL ed_result: got done=%0d err=%0d expected done=1 err=0", mon_done, mon_err); end
    n_checks++; if (mon_bad !== 0) begin n_fail++; $display("FAIL ed_pulse_busy: got %0d bad samples expected 0", mon_bad); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL ed_busy_end: got %b expected 0", tx_busy); end
    $display("test_send_ed: rx=%h par=%b stop=%b done=%0d inhibit=%0d", rx_byte, rx_par, rx_stop, mon_done, mon_inh);
  endtask

  task automatic test_parity;
    logic [7:0] bytes [3];
    logic       pars  [3];
    bytes[0] = 8'h01; pars[0] = 1'b0;
    bytes[1] = 8'h00; pars[1] = 1'b1;
    bytes[2] = 8'hFF; pars[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_xfer(bytes[k], 1'b1, 1'b1, 1'b0);
      n_checks++; if (rx_byte !== bytes[k]) begin n_fail++; $display("FAIL par_byte: got %h expected %h", rx_byte, bytes[k]); end
      n_checks++; if (rx_par !== pars[k]) begin n_fail++; $display("FAIL par_bit: byte %h got %b expected %b", bytes[k], rx_par, pars[k]); end
      n_checks++; if (mon_done !== 1 || mon_err !== 0) begin n_fail++; $display("FAIL par_result: got done=%0d err=%0d expected 1/0", mon_done, mon_err); end
      $display("test_parity: byte=%h rx=%h par=%b done=%0d", bytes[k], rx_byte, rx_par, mon_done);
    end
  endtask

  task automatic test_timeout;
    run_xfer(8'hED, 1'b0, 1'b0, 1'b0);
    n_checks++; if (mon_err !== 1 || mon_done !== 0) begin n_fail++; $display("FAIL to_result: got err=%0d done=%0d expected 1/0", mon_err, mon_done); end
    n_checks++; if (mon_err_cyc - mon_rel_cyc < TO - 2 || mon_err_cyc - mon_rel_cyc > TO + 2) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", mon_err_cyc - mon_rel_cyc, TO); end
    n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL to_release: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b expected 0", tx_busy); end
    $display("test_timeout: err=%0d latency=%0d", mon_err, mon_err_cyc - mon_rel_cyc);
  endtask

  task automatic test_no_ack;
    run_xfer(8'hED, 1'b1, 1'b0, 1'b0);
    n_checks++; if (mon_err !== 1 || mon_done !== 0) begin n_fail++; $display("FAIL noack_result: got err=%0d done=%0d expected 1/0", mon_err, mon_done); end
    n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL noack_release: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    n_checks++; if (mon_bad !== 0) begin n_fail++; $display("FAIL noack_pulse_busy: got %0d expected 0", mon_bad); end
    $display("test_no_ack: err=%0d done=%0d", mon_err, mon_done);
  endtask

  task automatic test_ignore_start;
    inj_busy = 1'b0;
    run_xfer(8'hED, 1'b1, 1'b1, 1'b1);
    n_checks++; if (inj_busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy_mid: got %b expected 1", inj_busy); end
    n_checks++; if (rx_byte !== 8'hED || rx_par !== 1'b1) begin n_fail++; $display("FAIL ign_byte: got %h/%b expected ed/1", rx_byte, rx_par); end
    n_checks++; if (mon_done !== 1 || mon_err !== 0) begin n_fail++; $display("FAIL ign_result: got done=%0d err=%0d expected 1/0", mon_done, mon_err); end
    repeat (100) @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL ign_no_requeue: got busy=%b clk_oe=%b expected 0/0", tx_busy, ps2_clk_oe); end
    $display("test_ignore_start: rx=%h done=%0d", rx_byte, mon_done);
  endtask

  task automatic test_back_to_back;
    bit   got;
    logic busy_after;
    got = 1'b0;
    busy_after = 1'b0;
    fork
      do_start(8'h01);
      device_run(1'b1, 1'b1);
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (tx_done) begin got = 1'b1; break; end
        end
        if (got) begin
          tx_data  = 8'hA5;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          busy_after = tx_busy;
        end
      end
    join
    n_checks++; if (got !== 1'b1 || rx_byte !== 8'h01) begin n_fail++; $display("FAIL b2b_first: got done=%b rx=%h expected 1/01", got, rx_byte); end
    n_checks++; if (busy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", busy_after); end
    fork
      device_run(1'b1, 1'b1);
      monitor(3000);
    join
    n_checks++; if (rx_byte !== 8'hA5 || rx_par !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h/%b expected a5/1", rx_byte, rx_par); end
    n_checks++; if (mon_done !== 1) begin n_fail++; $display("FAIL b2b_done: got %0d expected 1", mon_done); end
    $display("test_back_to_back: second rx=%h done=%0d", rx_byte, mon_done);
  endtask

  task automatic test_reset_mid;
    bit rts;
    rts = 1'b0;
    do_start(8'h00);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (clk_line && !dat_line) begin rts = 1'b1; break; end
    end
    repeat (5) @(negedge clk);
    // Four full clocks, then the fifth falling edge: host is now driving bit 4.
    for (int b = 0; b < 5; b++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (b < 4) begin
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
    n_checks++; if (rts !== 1'b1 || ps2_dat_oe !== 1'b1 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got rts=%b dat_oe=%b busy=%b expected 1/1/1", rts, ps2_dat_oe, tx_busy); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL rst_release: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_xfer(8'hF4, 1'b1, 1'b1, 1'b0);
    n_checks++; if (rx_byte !== 8'hF4 || rx_par !== 1'b0) begin n_fail++; $display("FAIL rst_f4_byte: got %h/%b expected f4/0", rx_byte, rx_par); end
    n_checks++; if (mon_done !== 1 || mon_err !== 0) begin n_fail++; $display("FAIL rst_f4_result: got done=%0d err=%0d expected 1/0", mon_done, mon_err); end
    $display("test_reset_mid: after reset rx=%h done=%0d", rx_byte, mon_done);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_timeout();
    test_no_ack();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
